// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared constants, FSM state type and small divide-by-3 helpers
// for the grid checker. No ports; imported by group_cell_map and grid_checker.
package sudoku_pkg;

    localparam int GRID_N = 9;
    localparam int CELLS  = 81;
    localparam int CELL_W = 4;
    localparam int GROUPS = 27;
    localparam int GRID_W = CELLS * CELL_W;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SCAN,
        DONE
    } state_t;

    // x / 3 for x in 0..8
    function automatic logic [1:0] div3(input logic [3:0] x);
        logic [1:0] r;
        if (x >= 4'd6)      r = 2'd2;
        else if (x >= 4'd3) r = 2'd1;
        else                r = 2'd0;
        return r;
    endfunction

    // x % 3 for x in 0..8
    function automatic logic [1:0] mod3(input logic [3:0] x);
        logic [3:0] r;
        if (x >= 4'd6)      r = x - 4'd6;
        else if (x >= 4'd3) r = x - 4'd3;
        else                r = x;
        return r[1:0];
    endfunction

    // 3 * v as shift-and-add
    function automatic logic [3:0] x3(input logic [1:0] v);
        return {1'b0, v, 1'b0} + {2'b00, v};
    endfunction

endpackage

// File: rtl/group_cell_map.sv
// group_cell_map: combinational map from (group g, cell-in-group k) to the
// flat cell index row*9+col. Ports: g[4:0] in, k[3:0] in, idx[6:0] out.
module group_cell_map
    import sudoku_pkg::*;
(
    input  logic [4:0] g,
    input  logic [3:0] k,
    output logic [6:0] idx
);

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] b;
    logic [4:0] g_off;

    always_comb begin
        row   = 4'd0;
        col   = 4'd0;
        b     = 4'd0;
        g_off = 5'd0;
        if (g < 5'd9) begin
            row = g[3:0];
            col = k;
        end else if (g < 5'd18) begin
            g_off = g - 5'd9;
            row   = k;
            col   = g_off[3:0];
        end else begin
            g_off = g - 5'd18;
            b     = g_off[3:0];
            row   = x3(div3(b)) + {2'b00, div3(k)};
            col   = x3(mod3(b)) + {2'b00, mod3(k)};
        end
    end

    // row*9 + col, built as (row<<3) + row + col
    assign idx = {row, 3'b000} + {3'b000, row} + {3'b000, col};

endmodule

// File: rtl/grid_checker.sv
// grid_checker: snapshots a 9x9 board and scans all 27 rows/cols/boxes one
// cell per cycle, reporting conflicts, empty cells and a win flag.
// Ports: clk, clr (async high), en, flat_grid[323:0] in;
//        win_flag, dup_flag, empty_count[6:0], pass_done, busy out.
module grid_checker
    import sudoku_pkg::*;
#(
    parameter int STICKY_WIN = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic [GRID_W-1:0]   flat_grid,
    output logic                win_flag,
    output logic                dup_flag,
    output logic [6:0]          empty_count,
    output logic                pass_done,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [4:0]          g_q, g_d;
    logic [3:0]          k_q, k_d;
    logic [GRID_W-1:0]   snap_q, snap_d;
    logic [8:0]          seen_q, seen_d;
    logic                conf_q, conf_d;
    logic [6:0]          empty_q, empty_d;
    logic                win_q, win_d;
    logic                dup_q, dup_d;
    logic [6:0]          ecount_q, ecount_d;
    logic                done_q, done_d;

    logic [6:0]          cell_idx;
    logic [3:0]          nib;
    logic [3:0]          vm1;
    logic [8:0]          onehot;
    logic [8:0]          seen_base;
    logic                last;
    logic                pass_ok;

    group_cell_map u_map (
        .g   (g_q),
        .k   (k_q),
        .idx (cell_idx)
    );

    assign nib       = snap_q[{cell_idx, 2'b00} +: CELL_W];
    assign vm1       = nib - 4'd1;
    assign onehot    = 9'd1 << vm1;
    // mask restarts at the first cell of every group
    assign seen_base = (k_q == 4'd0) ? 9'd0 : seen_q;
    assign last      = (g_q == 5'(GROUPS - 1)) && (k_q == 4'(GRID_N - 1));
    assign pass_ok   = (empty_q == 7'd0) && !conf_q;

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        k_d      = k_q;
        snap_d   = snap_q;
        seen_d   = seen_q;
        conf_d   = conf_q;
        empty_d  = empty_q;
        win_d    = win_q;
        dup_d    = dup_q;
        ecount_d = ecount_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) state_d = SNAP;
            end
            SNAP: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    snap_d  = flat_grid;
                    g_d     = 5'd0;
                    k_d     = 4'd0;
                    seen_d  = 9'd0;
                    conf_d  = 1'b0;
                    empty_d = 7'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    seen_d = seen_base;
                    if (nib == 4'd0) begin
                        // rows cover every cell exactly once
                        if (g_q < 5'd9) empty_d = empty_q + 7'd1;
                    end else if (nib > 4'd9) begin
                        conf_d = 1'b1;
                    end else if (|(seen_base & onehot)) begin
                        conf_d = 1'b1;
                    end else begin
                        seen_d = seen_base | onehot;
                    end

                    if (k_q == 4'd8) begin
                        k_d = 4'd0;
                        g_d = g_q + 5'd1;
                    end else begin
                        k_d = k_q + 4'd1;
                    end

                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                ecount_d = empty_q;
                dup_d    = conf_q;
                done_d   = 1'b1;
                if (STICKY_WIN != 0) win_d = win_q | pass_ok;
                else                 win_d = pass_ok;
                state_d  = en ? SNAP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            g_q      <= 5'd0;
            k_q      <= 4'd0;
            snap_q   <= '0;
            seen_q   <= 9'd0;
            conf_q   <= 1'b0;
            empty_q  <= 7'd0;
            win_q    <= 1'b0;
            dup_q    <= 1'b0;
            ecount_q <= 7'(CELLS);
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            k_q      <= k_d;
            snap_q   <= snap_d;
            seen_q   <= seen_d;
            conf_q   <= conf_d;
            empty_q  <= empty_d;
            win_q    <= win_d;
            dup_q    <= dup_d;
            ecount_q <= ecount_d;
            done_q   <= done_d;
        end
    end

    assign win_flag    = win_q;
    assign dup_flag    = dup_q;
    assign empty_count = ecount_q;
    assign pass_done   = done_q;
    assign busy        = (state_q == SNAP) || (state_q == SCAN);

endmodule

// File: tb/tb_grid_checker.sv
// tb_grid_checker: directed checks of grid_checker (STICKY_WIN=1) using a
// known puzzle, its solution and corrupted variants.
module tb_grid_checker;

    logic         clk;
    logic         clr;
    logic         en;
    logic [323:0] flat_grid;
    logic         win_flag;
    logic         dup_flag;
    logic [6:0]   empty_count;
    logic         pass_done;
    logic         busy;

    int tests = 0;
    int fails = 0;

    int puz [81] = '{
        0,0,0,2,6,0,7,0,1,
        6,8,0,0,7,0,0,9,0,
        1,9,0,0,0,4,5,0,0,
        8,2,0,1,0,0,0,4,0,
        0,0,4,6,0,2,9,0,0,
        0,5,0,0,0,3,0,2,8,
        0,0,9,3,0,0,0,7,4,
        0,4,0,0,5,0,0,3,6,
        7,0,3,0,1,8,0,0,0
    };

    int sol [81] = '{
        4,3,5,2,6,9,7,8,1,
        6,8,2,5,7,1,4,9,3,
        1,9,7,8,3,4,5,6,2,
        8,2,6,1,9,5,3,4,7,
        3,7,4,6,8,2,9,1,5,
        9,5,1,7,4,3,6,2,8,
        5,1,9,3,2,6,8,7,4,
        2,4,8,9,5,7,1,3,6,
        7,6,3,4,1,8,2,5,9
    };

    int tmp [81];

    grid_checker #(.STICKY_WIN(1)) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .flat_grid   (flat_grid),
        .win_flag    (win_flag),
        .dup_flag    (dup_flag),
        .empty_count (empty_count),
        .pass_done   (pass_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [323:0] pack(input int a [81]);
        logic [323:0] r;
        r = '0;
        for (int i = 0; i < 81; i++) r[i*4 +: 4] = 4'(a[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // raise en at a negedge and wait until the FSM enters SNAP
    task automatic start_pass();
        int i;
        @(negedge clk);
        en = 1'b1;
        for (i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) break;
        end
        chk("start_busy", int'(busy), 1);
    endtask

    // count rising edges until pass_done is seen (bounded)
    task automatic wait_pass(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (pass_done) break;
        end
    endtask

    task automatic stop_pass();
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int n;
        int seen;

        clr       = 1'b1;
        en        = 1'b0;
        flat_grid = '0;
        repeat (2) @(negedge clk);
        chk("rst_win", int'(win_flag), 0);
        chk("rst_dup", int'(dup_flag), 0);
        chk("rst_empty", int'(empty_count), 81);
        chk("rst_pd", int'(pass_done), 0);
        chk("rst_busy", int'(busy), 0);
        clr = 1'b0;

        // starting puzzle: 45 empty, no conflict
        flat_grid = pack(puz);
        start_pass();
        wait_pass(n);
        chk("puz_latency", n, 245);
        chk("puz_empty", int'(empty_count), 45);
        chk("puz_dup", int'(dup_flag), 0);
        chk("puz_win", int'(win_flag), 0);
        @(negedge clk);
        chk("puz_pd_pulse", int'(pass_done), 0);
        stop_pass();

        // cells 0 and 9 swapped: column fine, two rows conflict
        tmp    = sol;
        tmp[0] = sol[9];
        tmp[9] = sol[0];
        flat_grid = pack(tmp);
        start_pass();
        wait_pass(n);
        chk("swap_latency", n, 245);
        chk("swap_dup", int'(dup_flag), 1);
        chk("swap_empty", int'(empty_count), 0);
        chk("swap_win", int'(win_flag), 0);
        stop_pass();

        // illegal value 12 in the centre cell
        tmp     = sol;
        tmp[40] = 12;
        flat_grid = pack(tmp);
        start_pass();
        wait_pass(n);
        chk("ill_dup", int'(dup_flag), 1);
        chk("ill_empty", int'(empty_count), 0);
        chk("ill_win", int'(win_flag), 0);
        stop_pass();

        // solved grid wins; then zeroed grid keeps the sticky win
        flat_grid = pack(sol);
        start_pass();
        wait_pass(n);
        chk("sol_latency", n, 245);
        chk("sol_win", int'(win_flag), 1);
        chk("sol_dup", int'(dup_flag), 0);
        chk("sol_empty", int'(empty_count), 0);
        flat_grid = '0;
        wait_pass(n);
        chk("zero_latency", n, 245);
        chk("zero_empty", int'(empty_count), 81);
        chk("zero_dup", int'(dup_flag), 0);
        chk("zero_win_sticky", int'(win_flag), 1);
        stop_pass();

        pulse_clr();
        chk("clr_win", int'(win_flag), 0);
        chk("clr_empty", int'(empty_count), 81);

        // grid replaced by the solution at SCAN cycle 50
        flat_grid = pack(puz);
        start_pass();
        repeat (51) @(posedge clk);
        @(negedge clk);
        flat_grid = pack(sol);
        wait_pass(n);
        chk("chg_latency", n, 194);
        chk("chg1_empty", int'(empty_count), 45);
        chk("chg1_win", int'(win_flag), 0);
        chk("chg1_dup", int'(dup_flag), 0);
        wait_pass(n);
        chk("chg2_latency", n, 245);
        chk("chg2_win", int'(win_flag), 1);
        chk("chg2_empty", int'(empty_count), 0);

        // abort at SCAN cycle 100 with a puzzle snapshot in flight
        flat_grid = pack(puz);
        repeat (101) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pass_done) seen++;
        end
        chk("abort_no_pd", seen, 0);
        chk("abort_win", int'(win_flag), 1);
        chk("abort_empty", int'(empty_count), 0);
        chk("abort_dup", int'(dup_flag), 0);

        // clr between edges in the middle of a scan
        flat_grid = pack(tmp);
        start_pass();
        repeat (61) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        #1 clr = 1'b1;
        #1;
        chk("mclr_win", int'(win_flag), 0);
        chk("mclr_dup", int'(dup_flag), 0);
        chk("mclr_empty", int'(empty_count), 81);
        chk("mclr_pd", int'(pass_done), 0);
        chk("mclr_busy", int'(busy), 0);
        en = 1'b0;
        @(negedge clk);
        clr = 1'b0;

        // fresh pass after clr: snapshot and counters restart cleanly
        flat_grid = pack(puz);
        start_pass();
        wait_pass(n);
        chk("post_latency", n, 245);
        chk("post_empty", int'(empty_count), 45);
        chk("post_dup", int'(dup_flag), 0);
        stop_pass();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
